// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern source and the VGA output stage.
package vga_pkg;

    // Default active area of the 640x480 timing.
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    // 4-bit DAC intensity, same scale as vgadat.
    typedef logic [3:0] intensity_t;

    // Pattern mode encodings; 6 and 7 are reserved and render black.
    typedef enum logic [2:0] {
        MODE_SOLID   = 3'd0,
        MODE_BARS    = 3'd1,
        MODE_CHECKER = 3'd2,
        MODE_HRAMP   = 3'd3,
        MODE_VRAMP   = 3'd4,
        MODE_SCROLL  = 3'd5,
        MODE_RSVD6   = 3'd6,
        MODE_RSVD7   = 3'd7
    } mode_t;

endpackage

// File: rtl/vga_pattern_source_if.sv
// Pixel request / response and mode control bus between timing side and pattern source.
interface vga_pattern_source_if;
    logic       pix_req;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       frame_start;
    logic [2:0] mode_sel;
    logic       mode_wr;
    logic [3:0] pix_data;
    logic       pix_valid;
    logic [2:0] active_mode;
    logic [3:0] anim_step;

    // Timing / control side.
    modport master (
        output pix_req, pix_x, pix_y, frame_start, mode_sel, mode_wr,
        input  pix_data, pix_valid, active_mode, anim_step
    );

    // Pattern source side.
    modport slave (
        input  pix_req, pix_x, pix_y, frame_start, mode_sel, mode_wr,
        output pix_data, pix_valid, active_mode, anim_step
    );
endinterface

// File: rtl/vga_anim_ctr.sv
// Frame divider and animation phase: anim_step advances once every ANIM_DIV frames.
module vga_anim_ctr
    import vga_pkg::*;
#(
    parameter int unsigned ANIM_DIV = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    output intensity_t anim_step
);

    logic [7:0] frame_div;

    // Count frames; on the last frame of a period wrap the divider and step the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_div <= '0;
            anim_step <= '0;
        end else if (frame_start) begin
            if (frame_div == 8'(ANIM_DIV - 1)) begin
                frame_div <= '0;
                anim_step <= anim_step + 4'd1;
            end else begin
                frame_div <= frame_div + 8'd1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_source.sv
// Test-pattern pixel source: 2-cycle pipelined (x, y) -> intensity lookup with
// frame-synchronous mode switching and slow animation.
module vga_pattern_source
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned BAR_W    = 80,
    parameter int unsigned ANIM_DIV = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    vga_pattern_source_if.slave  pif
);

    mode_t      pending_mode;
    mode_t      act_mode;
    intensity_t anim_step;

    // Stage-1 comb precompute.
    logic [3:0]  bar_idx;
    intensity_t  bar_lvl;
    logic [10:0] scroll_sum;
    logic        in_range;

    // Stage-1 registers.
    logic       s1_valid;
    logic       s1_in_range;
    mode_t      s1_mode;
    intensity_t s1_anim;
    intensity_t s1_bar;
    logic       s1_chk;
    intensity_t s1_hramp;
    intensity_t s1_vramp;
    intensity_t s1_scroll;

    // Stage-2 select and registers.
    intensity_t sel_lvl;
    intensity_t pix_data_q;
    logic       pix_valid_q;

    vga_anim_ctr #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (pif.frame_start),
        .anim_step   (anim_step)
    );

    // Pending mode follows every write; active mode loads at frame start, taking a
    // same-cycle write directly so it is not lost for a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mode <= MODE_SOLID;
            act_mode     <= MODE_SOLID;
        end else begin
            if (pif.mode_wr) begin
                pending_mode <= mode_t'(pif.mode_sel);
            end
            if (pif.frame_start) begin
                act_mode <= pif.mode_wr ? mode_t'(pif.mode_sel) : pending_mode;
            end
        end
    end

    // Per-pixel precompute: bar index by compare chain, range check and scroll sum.
    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k <= 15; k++) begin
            if (32'(pif.pix_x) >= k * BAR_W) begin
                bar_idx = 4'(k);
            end
        end
        bar_lvl    = (bar_idx > 4'd7) ? 4'd15 : {bar_idx[2:0], 1'b0};
        scroll_sum = {1'b0, pif.pix_x} + {5'b0, anim_step, 2'b00};
        in_range   = (32'(pif.pix_x) < H_ACTIVE) && (32'(pif.pix_y) < V_ACTIVE);
    end

    // Stage 1: capture the request with the mode and phase in force at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_mode     <= MODE_SOLID;
            s1_anim     <= '0;
            s1_bar      <= '0;
            s1_chk      <= 1'b0;
            s1_hramp    <= '0;
            s1_vramp    <= '0;
            s1_scroll   <= '0;
        end else begin
            s1_valid <= pif.pix_req;
            if (pif.pix_req) begin
                s1_in_range <= in_range;
                s1_mode     <= act_mode;
                s1_anim     <= anim_step;
                s1_bar      <= bar_lvl;
                s1_chk      <= pif.pix_x[5] ^ pif.pix_y[5];
                s1_hramp    <= pif.pix_x[9:6];
                s1_vramp    <= pif.pix_y[8:5];
                s1_scroll   <= 4'(scroll_sum >> 6);
            end
        end
    end

    // Pick the level for the sampled mode; out-of-range and reserved modes are black.
    always_comb begin
        sel_lvl = '0;
        if (s1_in_range) begin
            case (s1_mode)
                MODE_SOLID:   sel_lvl = s1_anim;
                MODE_BARS:    sel_lvl = s1_bar;
                MODE_CHECKER: sel_lvl = s1_chk ? 4'd15 : 4'd0;
                MODE_HRAMP:   sel_lvl = s1_hramp;
                MODE_VRAMP:   sel_lvl = s1_vramp;
                MODE_SCROLL:  sel_lvl = s1_scroll;
                default:      sel_lvl = '0;
            endcase
        end
    end

    // Stage 2: register the pixel; data holds its last value between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            pix_valid_q <= s1_valid;
            if (s1_valid) begin
                pix_data_q <= sel_lvl;
            end
        end
    end

    assign pif.pix_data    = pix_data_q;
    assign pif.pix_valid   = pix_valid_q;
    assign pif.active_mode = act_mode;
    assign pif.anim_step   = anim_step;

endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed testbench for vga_pattern_source.
module tb_vga_pattern_source;

    logic clk;
    logic rst_n;
    int unsigned npass;
    int unsigned ntotal;

    vga_pattern_source_if bus ();

    vga_pattern_source #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .BAR_W    (80),
        .ANIM_DIV (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        ntotal++;
        if (obs == exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Single isolated request: valid must be low at +1 and high with data at +2.
    task automatic pixel(input string tag, input int x, input int y, input int exp);
        @(negedge clk);
        bus.pix_req = 1'b1;
        bus.pix_x   = 10'(x);
        bus.pix_y   = 10'(y);
        @(negedge clk);
        bus.pix_req = 1'b0;
        check({tag, "_v1"}, bus.pix_valid, 0);
        @(negedge clk);
        check({tag, "_v2"}, bus.pix_valid, 1);
        check({tag, "_d"}, bus.pix_data, exp);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic mode_write(input int m);
        @(negedge clk);
        bus.mode_sel = 3'(m);
        bus.mode_wr  = 1'b1;
        @(negedge clk);
        bus.mode_wr  = 1'b0;
    endtask

    task automatic mode_write_fs(input int m);
        @(negedge clk);
        bus.mode_sel    = 3'(m);
        bus.mode_wr     = 1'b1;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.mode_wr     = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        rst_n           = 1'b0;
        bus.pix_req     = 1'b0;
        bus.pix_x       = '0;
        bus.pix_y       = '0;
        bus.frame_start = 1'b0;
        bus.mode_sel    = '0;
        bus.mode_wr     = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid", bus.pix_valid, 0);
        check("rst_data", bus.pix_data, 0);
        check("rst_mode", bus.active_mode, 0);
        check("rst_anim", bus.anim_step, 0);
        rst_n = 1'b1;

        // Latency in mode 0 (anim_step 0).
        pixel("solid0", 100, 0, 0);
        @(negedge clk);
        check("solid0_v3", bus.pix_valid, 0);

        // Colour bars: frame 1.
        mode_write(1);
        check("bars_pending", bus.active_mode, 0);
        frame_pulse();
        check("bars_mode", bus.active_mode, 1);
        for (int i = 0; i < 642; i++) begin
            @(negedge clk);
            if (i < 640) begin
                bus.pix_req = 1'b1;
                bus.pix_x   = 10'(i);
                bus.pix_y   = 10'd10;
            end else begin
                bus.pix_req = 1'b0;
            end
            if (i >= 2) begin
                check($sformatf("bars_v_x%0d", i - 2), bus.pix_valid, 1);
                check($sformatf("bars_d_x%0d", i - 2), bus.pix_data, ((i - 2) / 80) * 2);
            end
        end
        @(negedge clk);
        check("bars_idle_v", bus.pix_valid, 0);
        check("bars_hold_d", bus.pix_data, 14);

        // Checker and out-of-range: frame 2.
        mode_write(2);
        frame_pulse();
        check("chk_mode", bus.active_mode, 2);
        pixel("chk_31_0", 31, 0, 0);
        pixel("chk_32_0", 32, 0, 15);
        pixel("oor_x640", 640, 0, 0);
        pixel("chk_33_1", 33, 1, 15);
        pixel("oor_y480", 0, 480, 0);
        pixel("chk_32_32", 32, 32, 0);

        // Write without frame start stays pending; bypass with frame start: frame 3.
        mode_write(4);
        @(negedge clk);
        check("pend_only", bus.active_mode, 2);
        mode_write_fs(3);
        check("bypass", bus.active_mode, 3);
        pixel("hramp_639", 639, 0, 9);
        pixel("hramp_64", 64, 5, 1);

        // Vertical ramp: frame 4.
        mode_write_fs(4);
        check("vramp_mode", bus.active_mode, 4);
        pixel("vramp_479", 0, 479, 14);
        pixel("vramp_31", 0, 31, 0);
        pixel("vramp_32", 0, 32, 1);

        // Animation: frames 5..14 keep phase 0, frame 15 steps it.
        check("anim_f4", bus.anim_step, 0);
        for (int f = 5; f <= 14; f++) frame_pulse();
        check("anim_f14", bus.anim_step, 0);
        frame_pulse();
        check("anim_f15", bus.anim_step, 1);
        for (int f = 16; f <= 239; f++) frame_pulse();
        check("anim_f239", bus.anim_step, 15);
        frame_pulse();
        check("anim_f240", bus.anim_step, 0);

        // Scroll with anim_step 1: frames 241..255.
        mode_write(5);
        for (int f = 241; f <= 255; f++) frame_pulse();
        check("scroll_mode", bus.active_mode, 5);
        check("anim_f255", bus.anim_step, 1);
        pixel("scroll_60", 60, 0, 1);
        pixel("scroll_59", 59, 0, 0);

        // Request coinciding with frame start uses the old mode; next one uses the new.
        mode_write(2);
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.pix_req     = 1'b1;
        bus.pix_x       = 10'd60;
        bus.pix_y       = 10'd0;
        @(negedge clk);
        bus.frame_start = 1'b0;
        @(negedge clk);
        bus.pix_req     = 1'b0;
        check("fs_same_v", bus.pix_valid, 1);
        check("fs_same_d", bus.pix_data, 1);
        check("fs_mode", bus.active_mode, 2);
        @(negedge clk);
        check("fs_next_v", bus.pix_valid, 1);
        check("fs_next_d", bus.pix_data, 15);

        // Solid follows anim_step.
        mode_write_fs(0);
        pixel("solid1", 5, 5, 1);

        // Reset while streaming.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.pix_req = 1'b1;
            bus.pix_x   = 10'(32 + i);
            bus.pix_y   = 10'd0;
        end
        check("stream_v", bus.pix_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_v", bus.pix_valid, 0);
        check("mid_rst_mode", bus.active_mode, 0);
        check("mid_rst_anim", bus.anim_step, 0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.pix_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_v%0d", i), bus.pix_valid, 0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
